// File: rtl/adder_pipelined.sv
// adder_pipelined: streaming WIDTH-bit adder whose carry chain is cut into STAGES registered segments.
// Define ADDER_PIPE_SUB_EN to add the `sub` port and the a + ~b + 1 subtraction mode.
module adder_pipelined #(
    parameter int WIDTH  = 135,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDER_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);
    localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
    localparam int LO_F = (STAGES - 1) * SEG;
    localparam int LAST = WIDTH - LO_F;

    logic           en_s;
    logic           sub_s;
    logic [WIDTH:0] sum_q, sum_d;
    logic           out_valid_q, out_valid_d;
    logic [LAST:0]  seg_f_s;

    assign en_s     = ~out_valid_q | out_ready;
    assign in_ready = en_s;
`ifdef ADDER_PIPE_SUB_EN
    assign sub_s    = sub;
`else
    assign sub_s    = 1'b0;
`endif

    // Level k holds the operands after k adder stages: a_q keeps resolved sum bits in
    // its low k*SEG bits, b_q keeps only the not-yet-consumed upper operand bits.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_lvl
            localparam int BW = WIDTH - k * SEG;
            logic [WIDTH-1:0] a_q, a_d;
            logic [BW-1:0]    b_q, b_d;
            logic             c_q, c_d;
            logic             v_q, v_d;

            if (k == 0) begin : g_in
                // Input register: subtraction is folded in as inverted b with carry-in 1.
                always_comb begin
                    a_d = a_q;
                    b_d = b_q;
                    c_d = c_q;
                    v_d = v_q;
                    if (en_s) begin
                        a_d = a;
                        b_d = sub_s ? ~b : b;
                        c_d = sub_s;
                        v_d = in_valid;
                    end else begin
                        a_d = a_q;
                    end
                end
            end else begin : g_add
                localparam int LO  = (k - 1) * SEG;
                localparam int BWP = WIDTH - (k - 1) * SEG;
                logic [SEG:0] seg_s;

                assign seg_s = {1'b0, g_lvl[k-1].a_q[LO +: SEG]}
                             + {1'b0, g_lvl[k-1].b_q[SEG-1:0]}
                             + {{SEG{1'b0}}, g_lvl[k-1].c_q};

                // Resolve one segment and shift the remaining b operand down.
                always_comb begin
                    a_d = a_q;
                    b_d = b_q;
                    c_d = c_q;
                    v_d = v_q;
                    if (en_s) begin
                        a_d              = g_lvl[k-1].a_q;
                        a_d[LO +: SEG]   = seg_s[SEG-1:0];
                        b_d              = g_lvl[k-1].b_q[BWP-1:SEG];
                        c_d              = seg_s[SEG];
                        v_d              = g_lvl[k-1].v_q;
                    end else begin
                        a_d = a_q;
                    end
                end
            end

            // Level state register; everything clears so no stale result survives reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= {WIDTH{1'b0}};
                    b_q <= {BW{1'b0}};
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    c_q <= c_d;
                    v_q <= v_d;
                end
            end
        end
    endgenerate

    assign seg_f_s = {1'b0, g_lvl[STAGES-1].a_q[WIDTH-1:LO_F]}
                   + {1'b0, g_lvl[STAGES-1].b_q}
                   + {{LAST{1'b0}}, g_lvl[STAGES-1].c_q};

    // Last segment; its carry-out lands directly in sum[WIDTH].
    always_comb begin
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (en_s) begin
            sum_d             = {1'b0, g_lvl[STAGES-1].a_q};
            sum_d[WIDTH:LO_F] = seg_f_s;
            out_valid_d       = g_lvl[STAGES-1].v_q;
        end else begin
            sum_d       = sum_q;
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= {(WIDTH + 1){1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// tb_adder_pipelined: scoreboard bench for adder_pipelined (WIDTH=135, STAGES=4, latency 5).
// Honours ADDER_PIPE_SUB_EN to exercise the subtraction mode.
module tb_adder_pipelined;
    localparam int W   = 135;
    localparam int LAT = 5;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W:0]   sum;
`ifdef ADDER_PIPE_SUB_EN
    logic         sub       = 1'b0;
`endif

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int last_stall = -1;
    logic [W:0] exp_q[$];
    int         t_q[$];

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    always #5 clk = ~clk;

    adder_pipelined #(.WIDTH(W), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    task automatic chk_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // One cycle: drive at negedge, sample #1 later, score outputs, record accepted inputs.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic is, input logic ordy, input string tag);
        logic [W:0] e;
        int         t;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
`ifdef ADDER_PIPE_SUB_EN
        sub       = is;
`endif
        #1;
        if (!in_ready) last_stall = cyc;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk_eq({tag, "_spurious"}, {{W{1'b0}}, out_valid}, {(W+1){1'b0}});
            end else begin
                chk_eq({tag, "_sum"}, sum, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    t = t_q.pop_front();
                    if (t > last_stall) chk_eq({tag, "_lat"}, (W+1)'(cyc - t), (W+1)'(LAT));
                end
            end
        end
        if (in_valid && in_ready) begin
            e = {1'b0, ia} + {1'b0, ib};
`ifdef ADDER_PIPE_SUB_EN
            if (is) e = {1'b0, ia} + {1'b0, ~ib} + {{W{1'b0}}, 1'b1};
`endif
            exp_q.push_back(e);
            t_q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, "idle");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_eq("reset_ov",  {{W{1'b0}}, out_valid}, {(W+1){1'b0}});
        chk_eq("reset_sum", sum, {(W+1){1'b0}});
        rst_n = 1'b1;
        #1;
        chk_eq("reset_rdy", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});

        // Full ripple through every segment.
        step(1'b1, ONES, ONE, 1'b0, 1'b1, "ripple");
        idle(LAT + 1);

        // Segment boundary and a wide carry into bit 101.
        step(1'b1, (ONE << 34) - ONE, ONE, 1'b0, 1'b1, "seg34");
        step(1'b1, (ONE << 101) - ONE, (ONE << 101) - ONE, 1'b0, 1'b1, "b101");
        idle(LAT + 1);

        // Back-to-back random stream.
        for (int i = 0; i < 10; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, "stream");
        idle(LAT + 1);

        // Fill, stall three cycles, resume.
        for (int i = 0; i < LAT; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, "fill");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rnd(), rnd(), 1'b0, 1'b0, "stall");
            chk_eq("stall_rdy", {{W{1'b0}}, in_ready}, {(W+1){1'b0}});
            chk_eq("stall_ov",  {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        end
        for (int i = 0; i < 4; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, "resume");
        idle(LAT + 2);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, "prerst");
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_eq("midrst_ov",  {{W{1'b0}}, out_valid}, {(W+1){1'b0}});
        chk_eq("midrst_sum", sum, {(W+1){1'b0}});
        exp_q.delete();
        t_q.delete();
        @(posedge clk);
        #1;
        chk_eq("midrst_hold", {{W{1'b0}}, out_valid}, {(W+1){1'b0}});
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, rnd(), rnd(), 1'b0, 1'b1, "postrst");
        idle(LAT + 1);

`ifdef ADDER_PIPE_SUB_EN
        step(1'b1, 135'd5, 135'd7, 1'b1, 1'b1, "sub57");
        step(1'b1, 135'd7, 135'd5, 1'b1, 1'b1, "sub75");
        step(1'b1, rnd(), rnd(), 1'b0, 1'b1, "submix");
        idle(LAT + 1);
`endif

        chk_eq("drain", (W+1)'(exp_q.size()), {(W+1){1'b0}});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
